// File: rtl/jump_exec_if.sv
// Decode/regfile -> jump execute stage -> fetch/write-back signal bundle.
// trap_valid/trap_pc are present only when JUMP_MISALIGN_TRAP_EN is defined.
interface jump_exec_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] pc;
  logic [1:0]  jump_control;
  logic [4:0]  rd;
  logic [31:0] rs1_data;
  logic [20:0] imm;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ack;
  logic        flush;
  logic        busy;
`ifdef JUMP_MISALIGN_TRAP_EN
  logic        trap_valid;
  logic [31:0] trap_pc;
`endif

  modport slave (
    input  in_valid, pc, jump_control, rd, rs1_data, imm, redirect_ack,
    output in_ready, wb_valid, wb_rd, wb_data, redirect_valid, redirect_pc, flush, busy
`ifdef JUMP_MISALIGN_TRAP_EN
    , trap_valid, trap_pc
`endif
  );

  modport master (
    output in_valid, pc, jump_control, rd, rs1_data, imm, redirect_ack,
    input  in_ready, wb_valid, wb_rd, wb_data, redirect_valid, redirect_pc, flush, busy
`ifdef JUMP_MISALIGN_TRAP_EN
    , trap_valid, trap_pc
`endif
  );
endinterface

// File: rtl/jump_exec_stage.sv
// JAL/JALR execute: link write-back, PC redirect handshake, fixed-length flush.
// States: IDLE accept | REDIRECT hold until ack | FLUSH count down. Option: JUMP_MISALIGN_TRAP_EN.
module jump_exec_stage #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic       clk,
  input logic       rst,
  jump_exec_if.slave jx
);
  localparam logic [1:0] JMP_NOP = 2'b00;
  localparam logic [1:0] JMP_JAL = 2'b01;
  localparam logic [1:0] JMP_JALR = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_REDIRECT, S_FLUSH} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        is_jal, is_jalr, accept;
  logic [31:0] jal_tgt, jalr_sum, target;
`ifdef JUMP_MISALIGN_TRAP_EN
  logic        mis_q, mis_d;
  logic [31:0] trap_pc_q, trap_pc_d;
`endif

  always_comb begin
    is_jal   = (jx.jump_control == JMP_JAL);
    is_jalr  = (jx.jump_control == JMP_JALR);
    accept   = jx.in_valid & (state_q == S_IDLE);
    jal_tgt  = jx.pc + {{11{jx.imm[20]}}, jx.imm};
    jalr_sum = jx.rs1_data + {{20{jx.imm[11]}}, jx.imm[11:0]};
    target   = is_jalr ? (jalr_sum & ~32'h1) : jal_tgt;
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    wb_valid_d    = 1'b0;
    wb_rd_d       = wb_rd_q;
    wb_data_d     = wb_data_q;
    redirect_pc_d = redirect_pc_q;
`ifdef JUMP_MISALIGN_TRAP_EN
    mis_d     = mis_q;
    trap_pc_d = trap_pc_q;
`endif
    case (state_q)
      S_IDLE: begin
        // NOP and the unused encoding are consumed here without effect
        if (accept && (is_jal || is_jalr)) begin
          state_d       = S_REDIRECT;
          wb_rd_d       = jx.rd;
          wb_data_d     = jx.pc + 32'd4;
          redirect_pc_d = target;
`ifdef JUMP_MISALIGN_TRAP_EN
          mis_d      = target[1];
          trap_pc_d  = jx.pc;
          wb_valid_d = ~target[1];
`else
          wb_valid_d = 1'b1;
`endif
        end
      end
      S_REDIRECT: begin
        // exactly one of redirect_valid/trap_valid is up here, so ack alone completes
        if (jx.redirect_ack) begin
          state_d = S_FLUSH;
          cnt_d   = FLUSH_CYCLES[3:0];
        end
      end
      S_FLUSH: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= 4'd0;
      wb_valid_q    <= 1'b0;
      wb_rd_q       <= 5'd0;
      wb_data_q     <= 32'd0;
      redirect_pc_q <= 32'd0;
`ifdef JUMP_MISALIGN_TRAP_EN
      mis_q     <= 1'b0;
      trap_pc_q <= 32'd0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wb_valid_q    <= wb_valid_d;
      wb_rd_q       <= wb_rd_d;
      wb_data_q     <= wb_data_d;
      redirect_pc_q <= redirect_pc_d;
`ifdef JUMP_MISALIGN_TRAP_EN
      mis_q     <= mis_d;
      trap_pc_q <= trap_pc_d;
`endif
    end
  end

  assign jx.in_ready    = (state_q == S_IDLE);
  assign jx.busy        = (state_q != S_IDLE);
  assign jx.flush       = (state_q == S_FLUSH);
  assign jx.wb_valid    = wb_valid_q;
  assign jx.wb_rd       = wb_rd_q;
  assign jx.wb_data     = wb_data_q;
  assign jx.redirect_pc = redirect_pc_q;
`ifdef JUMP_MISALIGN_TRAP_EN
  assign jx.redirect_valid = (state_q == S_REDIRECT) & ~mis_q;
  assign jx.trap_valid     = (state_q == S_REDIRECT) & mis_q;
  assign jx.trap_pc        = trap_pc_q;
`else
  assign jx.redirect_valid = (state_q == S_REDIRECT);
`endif

  logic unused_nop;
  assign unused_nop = ^JMP_NOP;
endmodule
